// File: rtl/mcycle_arith_unit.sv
// Multi-cycle integer multiply/divide unit: one bit per clock, shift-add multiply and
// restoring divide on operand magnitudes, with sign correction applied in a final cycle.
module mcycle_arith_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic [1:0]       Flags,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mag_q;
  logic [WIDTH-1:0]     op1_q;
  logic                 is_div_q, neg_q, rem_neg_q, dbz_q;
  logic [WIDTH-1:0]     result1_q, result2_q;
  logic [1:0]           flags_q;
  logic                 div_by_zero_q, busy_q, done_q;

  // Operand capture
  logic                 sgn1, sgn2;
  logic [WIDTH-1:0]     mag1, mag2;

  // Iteration datapath
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH-1:0]   mul_d, div_d;
  logic                 unused_diff_msb;

  // Final sign correction
  logic [2*WIDTH-1:0]   fin_prod;
  logic [WIDTH-1:0]     fin_quo, fin_rem, fin_r1, fin_r2;
  logic [1:0]           fin_flags;
  logic                 fin_dbz;

  always_comb begin
    sgn1 = MCycleOp[0] & Operand1[WIDTH-1];
    sgn2 = MCycleOp[0] & Operand2[WIDTH-1];
    mag1 = sgn1 ? ('0 - Operand1) : Operand1;
    mag2 = sgn2 ? ('0 - Operand2) : Operand2;
  end

  always_comb begin
    // Multiply: acc = {partial high, remaining multiplier bits}
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    mul_d   = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    // Divide: acc = {partial remainder, dividend/quotient}; borrow restores
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mag_q};
    if (diff[WIDTH+1]) begin
      div_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // A non-borrowing difference is below the divisor, so its top bit is always zero.
  assign unused_diff_msb = diff[WIDTH];

  always_comb begin
    fin_prod = neg_q ? ('0 - acc_q) : acc_q;
    fin_quo  = neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    fin_rem  = rem_neg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    fin_dbz  = 1'b0;
    if (!is_div_q) begin
      fin_r1    = fin_prod[WIDTH-1:0];
      fin_r2    = fin_prod[2*WIDTH-1:WIDTH];
      fin_flags = {fin_r2[WIDTH-1], (fin_prod == '0)};
    end else begin
      if (dbz_q) begin
        fin_r1  = '1;
        fin_r2  = op1_q;
        fin_dbz = 1'b1;
      end else begin
        fin_r1  = fin_quo;
        fin_r2  = fin_rem;
      end
      fin_flags = {fin_r1[WIDTH-1], (fin_r1 == '0)};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      acc_q         <= '0;
      mag_q         <= '0;
      op1_q         <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      result1_q     <= '0;
      result2_q     <= '0;
      flags_q       <= '0;
      div_by_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (Start) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            is_div_q  <= MCycleOp[1];
            op1_q     <= Operand1;
            rem_neg_q <= MCycleOp[1] & sgn1;
            neg_q     <= sgn1 ^ sgn2;
            dbz_q     <= MCycleOp[1] & (Operand2 == '0);
            if (MCycleOp[1]) begin
              acc_q <= {{WIDTH{1'b0}}, mag1};
              mag_q <= mag2;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, mag2};
              mag_q <= mag1;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          acc_q <= is_div_q ? div_d : mul_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          result1_q     <= fin_r1;
          result2_q     <= fin_r2;
          flags_q       <= fin_flags;
          div_by_zero_q <= fin_dbz;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          state_q       <= StDone;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Result1   = result1_q;
  assign Result2   = result2_q;
  assign Flags     = flags_q;
  assign DivByZero = div_by_zero_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule
